// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised rx line, centre-sampled bits, LSB first.
// Latency: rx_valid rises one clk after the stop-bit sample.
// Backpressure: single holding register; a byte arriving while it is full is dropped with an overrun pulse.
module uart_rx #(
  parameter int BAUD_DIV    = 434,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic                   w_rx_s;
  logic                   w_tick;
  logic                   w_start;
  logic                   w_deliver;
  logic                   w_frame_bad;

  assign w_rx_s = r_sync[SYNC_STAGES-1];
  assign busy   = (r_state != S_IDLE);

  // Sample events only exist while a frame is being timed.
  assign w_tick = ((r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP))
                  && (r_cnt == '0);

  // Input synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic plus the strobes that drive the datapath.
  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_deliver   = 1'b0;
    w_frame_bad = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_start = 1'b1;
          w_next  = S_START;
        end
      end
      S_START: begin
        // A start bit that is high again at its centre is a glitch.
        if (w_tick) begin
          w_next = w_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_tick && (r_bit_cnt == 3'd7)) begin
          w_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (w_rx_s) begin
            w_deliver = 1'b1;
            w_next    = S_IDLE;
          end else begin
            w_frame_bad = 1'b1;
            w_next      = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Hold off until the line goes idle so a long low produces one error only.
        if (w_rx_s) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Baud counter: half-bit load on start detect, full-bit reload on every sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= HALF_LOAD;
    end else if ((r_state == S_IDLE) || (r_state == S_BREAK)) begin
      r_cnt <= '0;
    end else if (r_cnt == '0) begin
      r_cnt <= FULL_LOAD;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Bit counter and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if ((r_state == S_START) && w_tick) begin
      r_bit_cnt <= '0;
    end else if ((r_state == S_DATA) && w_tick) begin
      r_shift   <= {w_rx_s, r_shift[7:1]};
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  // Holding register and error pulses; a drain in the delivery cycle makes room.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= w_frame_bad;
      overrun   <= w_deliver && rx_valid && !rx_ready;
      if (w_deliver && (!rx_valid || rx_ready)) begin
        rx_data  <= r_shift;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at BAUD_DIV=16: table of serial frames plus directed
// sequences for glitch, overrun, same-cycle accept and mid-frame reset.
module tb_uart_rx;

  localparam int BD = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad = 0;

  // Event counters, written only by the monitor.
  int         acc_cnt = 0;
  int         vcyc_cnt = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         busy_cnt = 0;
  logic [7:0] last_acc = 8'h00;

  uart_rx #(.BAUD_DIV(BD), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .frame_err(frame_err),
    .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Sample outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) vcyc_cnt++;
    if (rx_valid && rx_ready) begin
      acc_cnt++;
      last_acc = rx_data;
    end
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (busy) busy_cnt++;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         hold;
    int         exp_bytes;
    int         exp_fe;
    int         exp_busy;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_cyc(BD);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int hold_bits);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_bit);
    for (int i = 0; i < hold_bits; i++) send_bit(1'b0);
    rx = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_acc, b_vc, b_fe, b_ov, b_busy;

    // data, stop, hold bits, bytes, frame errors, busy cycles
    vecs[0] = '{8'hA5, 1'b1, 0, 1, 0, 152};
    vecs[1] = '{8'h00, 1'b1, 0, 1, 0, 152};
    vecs[2] = '{8'hFF, 1'b1, 0, 1, 0, 152};
    vecs[3] = '{8'h3C, 1'b0, 3, 0, 1, 208};
    vecs[4] = '{8'h81, 1'b1, 0, 1, 0, 152};
    vecs[5] = '{8'h55, 1'b0, 0, 0, 1, 160};

    // Reset state
    wait_cyc(3);
    check("reset rx_data", int'(rx_data), 0);
    check("reset rx_valid", int'(rx_valid), 0);
    check("reset frame_err", int'(frame_err), 0);
    check("reset overrun", int'(overrun), 0);
    check("reset busy", int'(busy), 0);
    rst = 1'b0;
    wait_cyc(4);

    // Table of frames with rx_ready held high
    for (int vi = 0; vi < 6; vi++) begin
      b_acc = acc_cnt; b_vc = vcyc_cnt; b_fe = fe_cnt; b_ov = ov_cnt; b_busy = busy_cnt;
      send_frame(vecs[vi].data, vecs[vi].stop_bit, vecs[vi].hold);
      wait_cyc(2 * BD);
      check($sformatf("vec%0d bytes", vi), acc_cnt - b_acc, vecs[vi].exp_bytes);
      check($sformatf("vec%0d valid cycles", vi), vcyc_cnt - b_vc, vecs[vi].exp_bytes);
      check($sformatf("vec%0d frame_err", vi), fe_cnt - b_fe, vecs[vi].exp_fe);
      check($sformatf("vec%0d overrun", vi), ov_cnt - b_ov, 0);
      check($sformatf("vec%0d busy cycles", vi), busy_cnt - b_busy, vecs[vi].exp_busy);
      check($sformatf("vec%0d busy end", vi), int'(busy), 0);
      if (vecs[vi].exp_bytes == 1)
        check($sformatf("vec%0d byte", vi), int'(last_acc), int'(vecs[vi].data));
    end

    // Glitch: 4 low cycles, rejected at the start-bit centre
    b_acc = acc_cnt; b_vc = vcyc_cnt; b_fe = fe_cnt; b_ov = ov_cnt; b_busy = busy_cnt;
    rx = 1'b0;
    wait_cyc(4);
    rx = 1'b1;
    wait_cyc(2 * BD);
    check("glitch busy cycles", busy_cnt - b_busy, 8);
    check("glitch valid cycles", vcyc_cnt - b_vc, 0);
    check("glitch frame_err", fe_cnt - b_fe, 0);
    check("glitch overrun", ov_cnt - b_ov, 0);

    // Overrun: two back-to-back bytes with no consumer
    rx_ready = 1'b0;
    b_acc = acc_cnt; b_fe = fe_cnt; b_ov = ov_cnt;
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    wait_cyc(2 * BD);
    check("ovr rx_valid held", int'(rx_valid), 1);
    check("ovr rx_data held", int'(rx_data), 8'h11);
    check("ovr pulses", ov_cnt - b_ov, 1);
    check("ovr frame_err", fe_cnt - b_fe, 0);
    check("ovr no accept", acc_cnt - b_acc, 0);
    rx_ready = 1'b1;
    wait_cyc(1);
    rx_ready = 1'b0;
    check("ovr drain valid", int'(rx_valid), 0);
    check("ovr drain count", acc_cnt - b_acc, 1);
    check("ovr drain byte", int'(last_acc), 8'h11);

    // Accept in exactly the cycle the second byte is delivered
    wait_cyc(2 * BD);
    b_acc = acc_cnt; b_ov = ov_cnt;
    send_frame(8'h11, 1'b1, 0);
    fork
      send_frame(8'h22, 1'b1, 0);
      begin
        wait_cyc(154);
        check("simul before data", int'(rx_data), 8'h11);
        check("simul before valid", int'(rx_valid), 1);
        rx_ready = 1'b1;
        wait_cyc(1);
        rx_ready = 1'b0;
        check("simul after data", int'(rx_data), 8'h22);
        check("simul after valid", int'(rx_valid), 1);
      end
    join
    wait_cyc(2 * BD);
    check("simul overrun", ov_cnt - b_ov, 0);
    check("simul accepted", acc_cnt - b_acc, 1);
    check("simul first byte", int'(last_acc), 8'h11);
    rx_ready = 1'b1;
    wait_cyc(1);
    check("simul drain byte", int'(last_acc), 8'h22);
    check("simul drain valid", int'(rx_valid), 0);

    // Reset during data bit 4 of 0xF0, then receive 0x0F
    wait_cyc(2 * BD);
    b_acc = acc_cnt; b_fe = fe_cnt; b_ov = ov_cnt;
    fork
      send_frame(8'hF0, 1'b1, 0);
      begin
        wait_cyc(5 * BD + 8);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        check("midrst busy", int'(busy), 0);
        check("midrst rx_valid", int'(rx_valid), 0);
        check("midrst rx_data", int'(rx_data), 0);
        check("midrst frame_err", int'(frame_err), 0);
        check("midrst overrun", int'(overrun), 0);
      end
    join
    wait_cyc(2 * BD);
    send_frame(8'h0F, 1'b1, 0);
    wait_cyc(2 * BD);
    check("midrst bytes", acc_cnt - b_acc, 1);
    check("midrst byte", int'(last_acc), 8'h0F);
    check("midrst frame_err total", fe_cnt - b_fe, 0);
    check("midrst overrun total", ov_cnt - b_ov, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
